// File: rtl/shift_norm_pkg.sv
// Shared definitions for the iterative shift normalizer: datapath widths,
// normalization modes, FSM states and the mode decoder.
package shift_norm_pkg;

    localparam int WIDTH = 32;
    localparam int AMT_W = 5;

    typedef enum logic [1:0] {
        MODE_LEFT  = 2'b00,
        MODE_RIGHT = 2'b01,
        MODE_SIGN  = 2'b10
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

    // Encoding 11 is an alias of LEFT, so it folds into MODE_LEFT at capture.
    function automatic mode_e decode_mode(input logic [1:0] m);
        case (m)
            2'b01:   return MODE_RIGHT;
            2'b10:   return MODE_SIGN;
            default: return MODE_LEFT;
        endcase
    endfunction

endpackage

// File: rtl/shift_norm_step.sv
// One normalization step: evaluates the stop condition on the working word
// and produces the shifted word and count for the next cycle.
// Optional feature: SHIFT_NORM_NIBBLE_EN enables 4-position steps when none
// of the next four single steps could stop.
module shift_norm_step
    import shift_norm_pkg::*;
(
    input  logic [WIDTH-1:0] work_i,
    input  mode_e            mode_i,
    input  logic [AMT_W-1:0] cnt_i,
    output logic             stop_o,
    output logic [WIDTH-1:0] work_o,
    output logic [AMT_W-1:0] cnt_o
);

`ifdef SHIFT_NORM_NIBBLE_EN
    logic nib_ok;
`endif

    // Stop detection plus next working word / count.
    always_comb begin
        stop_o = (cnt_i == AMT_W'(WIDTH - 1));
        case (mode_i)
            MODE_RIGHT: stop_o = stop_o | work_i[0];
            MODE_SIGN:  stop_o = stop_o | (work_i[WIDTH-1] ^ work_i[WIDTH-2]);
            default:    stop_o = stop_o | work_i[WIDTH-1];
        endcase

        work_o = (mode_i == MODE_RIGHT) ? (work_i >> 1) : (work_i << 1);
        cnt_o  = cnt_i + AMT_W'(1);

`ifdef SHIFT_NORM_NIBBLE_EN
        // A nibble step is safe only if none of the four bits it skips past
        // would have triggered a stop, and the cap cannot be crossed.
        case (mode_i)
            MODE_RIGHT: nib_ok = (work_i[3:0] == 4'h0);
            MODE_SIGN:  nib_ok = (work_i[WIDTH-1:WIDTH-5] == 5'b00000) ||
                                 (work_i[WIDTH-1:WIDTH-5] == 5'b11111);
            default:    nib_ok = (work_i[WIDTH-1:WIDTH-4] == 4'h0);
        endcase
        if (!stop_o && nib_ok && (cnt_i <= AMT_W'(WIDTH - 5))) begin
            work_o = (mode_i == MODE_RIGHT) ? (work_i >> 4) : (work_i << 4);
            cnt_o  = cnt_i + AMT_W'(4);
        end
`endif
    end

endmodule

// File: rtl/shift_normalizer.sv
// Iterative normalizer: recovers the shift amount of a word (leading-zero,
// trailing-zero or redundant-sign count) with valid/ready on both sides,
// one operation in flight. Optional feature macro: SHIFT_NORM_NIBBLE_EN
// (faster stepping inside shift_norm_step; results are unchanged).
module shift_normalizer
    import shift_norm_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [AMT_W-1:0] out_amt,
    output logic             out_zero
);

    state_e           state_q, state_d;
    mode_e            mode_q, mode_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [AMT_W-1:0] cnt_q, cnt_d;
    logic             zero_q, zero_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [AMT_W-1:0] out_amt_q, out_amt_d;
    logic             out_zero_q, out_zero_d;

    logic             step_stop;
    logic [WIDTH-1:0] step_work;
    logic [AMT_W-1:0] step_cnt;
    mode_e            in_mode;

    assign in_mode = decode_mode(mode);

    shift_norm_step u_step (
        .work_i (work_q),
        .mode_i (mode_q),
        .cnt_i  (cnt_q),
        .stop_o (step_stop),
        .work_o (step_work),
        .cnt_o  (step_cnt)
    );

    // Next-state logic for the IDLE -> SHIFT -> DONE handshake sequence.
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        work_d      = work_q;
        cnt_d       = cnt_q;
        zero_d      = zero_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_amt_d   = out_amt_q;
        out_zero_d  = out_zero_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    work_d     = in_data;
                    mode_d     = in_mode;
                    cnt_d      = '0;
                    zero_d     = (in_data == '0) ||
                                 ((in_mode == MODE_SIGN) && (in_data == '1));
                    in_ready_d = 1'b0;
                    state_d    = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (step_stop) begin
                    out_data_d  = work_q;
                    out_amt_d   = cnt_q;
                    out_zero_d  = zero_q;
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end else begin
                    work_d = step_work;
                    cnt_d  = step_cnt;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset discards any partial operation.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            mode_q      <= MODE_LEFT;
            work_q      <= '0;
            cnt_q       <= '0;
            zero_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_amt_q   <= '0;
            out_zero_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            work_q      <= work_d;
            cnt_q       <= cnt_d;
            zero_q      <= zero_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_amt_q   <= out_amt_d;
            out_zero_q  <= out_zero_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_amt   = out_amt_q;
    assign out_zero  = out_zero_q;

endmodule

// File: tb/tb_shift_normalizer.sv
// Self-checking bench for shift_normalizer: directed cases from the block's
// behaviour description plus randomized operations checked against a
// counting model of leading/trailing/redundant-sign bits.
module tb_shift_normalizer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [1:0]  mode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_amt;
    logic        out_zero;

    int errors = 0;
    int checks = 0;

    logic [31:0] exp_data;
    logic [4:0]  exp_amt;
    logic        exp_zero;
    int          exp_lat;
    bit          exp_valid = 1'b0;

    shift_normalizer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_amt   (out_amt),
        .out_zero  (out_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: count stop-free positions directly from the input word.
    function automatic void model(input logic [1:0] m, input logic [31:0] d,
                                  output logic [31:0] od, output logic [4:0] oa,
                                  output logic oz, output int lat);
        int n;
        n = 0;
        if (m == 2'b01) begin
            while (n < 32 && d[n] == 1'b0) n++;
        end else if (m == 2'b10) begin
            while (n < 32 && d[31-n] == d[31]) n++;
            n = n - 1;
        end else begin
            while (n < 32 && d[31-n] == 1'b0) n++;
        end
        if (n > 31) n = 31;
        oa = 5'(n);
        od = (m == 2'b01) ? (d >> n) : (d << n);
        oz = (d == 32'h0) || (m == 2'b10 && d == 32'hFFFFFFFF);
`ifdef SHIFT_NORM_NIBBLE_EN
        lat = n / 4 + n % 4 + 1;
`else
        lat = n + 1;
`endif
    endfunction

    // Whenever a result is presented, it must match the model and the input side must be closed.
    always @(negedge clk) begin
        if (rst_n && exp_valid && out_valid) begin
            chk("out_data", out_data, exp_data);
            chk("out_amt", 32'(out_amt), 32'(exp_amt));
            chk("out_zero", 32'(out_zero), 32'(exp_zero));
            chk("in_ready_busy", 32'(in_ready), 32'd0);
        end
    end

    task automatic run_op(input logic [1:0] m, input logic [31:0] d, input int hold,
                          input bit early, output int lat);
        bit got;
        model(m, d, exp_data, exp_amt, exp_zero, exp_lat);
        @(negedge clk);
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        in_data   = d;
        mode      = m;
        out_ready = early;
        exp_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = $urandom;
        mode     = 2'($urandom);
        lat = 0;
        while (lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (out_valid) break;
        end
        got = out_valid;
        chk("valid_timeout", 32'(got), 32'd1);
        chk("latency", 32'(lat), 32'(exp_lat));
        if (!early) begin
            repeat (hold) @(posedge clk);
            #1;
            out_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        chk("valid_drop", 32'(out_valid), 32'd0);
        chk("ready_back", 32'(in_ready), 32'd1);
        $display("op mode=%0d in=%h -> data=%h amt=%0d zero=%0d lat=%0d",
                 m, d, exp_data, exp_amt, exp_zero, lat);
        out_ready = 1'b0;
        exp_valid = 1'b0;
    endtask

    initial begin
        int lat;
        int bad;
        logic [31:0] md;
        logic [4:0]  ma;
        logic        mz;
        int          ml;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        mode      = 2'b00;
        out_ready = 1'b0;

        // Pin the model itself with hand-computed values.
        model(2'b00, 32'h29696969, md, ma, mz, ml);
        chk("pin_left_data", md, 32'hA5A5A5A4);
        chk("pin_left_amt", 32'(ma), 32'd2);
        model(2'b01, 32'h96969694, md, ma, mz, ml);
        chk("pin_right_data", md, 32'h25A5A5A5);
        model(2'b10, 32'hFFFFFFFF, md, ma, mz, ml);
        chk("pin_sign_ones", md, 32'h80000000);
        chk("pin_sign_ones_amt", 32'(ma), 32'd31);
        chk("pin_sign_ones_zero", 32'(mz), 32'd1);

        // Reset values.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_amt", 32'(out_amt), 32'd0);
        chk("rst_out_zero", 32'(out_zero), 32'd0);
        rst_n = 1'b1;

        // Directed cases.
        run_op(2'b00, 32'h29696969, 0, 1'b0, lat);
        chk("lat_left", 32'(lat), 32'd3);
        run_op(2'b01, 32'h96969694, 1, 1'b0, lat);
        run_op(2'b00, 32'h80000000, 0, 1'b1, lat);
        chk("lat_min", 32'(lat), 32'd1);
        run_op(2'b10, 32'hE9696969, 0, 1'b0, lat);
        run_op(2'b10, 32'hFFFFFFFF, 0, 1'b0, lat);
        run_op(2'b11, 32'h00010000, 0, 1'b0, lat);
        run_op(2'b00, 32'h00000000, 0, 1'b0, lat);
`ifdef SHIFT_NORM_NIBBLE_EN
        chk("lat_zero", 32'(lat), 32'd11);
`else
        chk("lat_zero", 32'(lat), 32'd32);
`endif
        // Backpressure: result held for 5 stalled cycles (monitor checks each one).
        run_op(2'b01, 32'h00000100, 5, 1'b0, lat);

        // Reset in the middle of a long operation.
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 32'h0;
        mode     = 2'b00;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_out_amt", 32'(out_amt), 32'd0);
        chk("midrst_out_data", out_data, 32'd0);
        bad = 0;
        for (int i = 0; i < 36; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) bad++;
        end
        chk("midrst_no_result", 32'(bad), 32'd0);
        run_op(2'b00, 32'h29696969, 0, 1'b0, lat);
        chk("lat_after_rst", 32'(lat), 32'd3);

        // Randomized operations over a spread of shift amounts.
        for (int t = 0; t < 60; t++) begin
            logic [31:0] d;
            int sh;
            d  = $urandom;
            sh = $urandom_range(0, 31);
            case ($urandom_range(0, 5))
                0: d = d >> sh;
                1: d = d << sh;
                2: d = $unsigned($signed(d) >>> sh);
                3: d = ($urandom_range(0, 1) == 0) ? 32'h0 : 32'hFFFFFFFF;
                default: d = d;
            endcase
            run_op(2'($urandom), d, $urandom_range(0, 3), 1'($urandom), lat);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
